// File: rtl/program_loader.sv
// program_loader: boot-time loader that assembles big-endian 32-bit words from
// a byte stream, writes them into the core's memory from address 0, verifies a
// trailing XOR checksum and holds the core in reset until a clean load.
module program_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_t;

  // Largest legal word_count: the full memory, 2**ADDR_W words.
  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};

  state_t          state;
  logic [ADDR_W:0] count;
  logic [ADDR_W:0] index;
  logic [ADDR_W:0] index_inc;
  logic [1:0]      byte_cnt;
  logic [7:0]      csum;
  logic [23:0]     word;

  // Status outputs registered together with the state they describe:
  // {byte_ready, busy, done, error, cpu_rst}.
  function automatic logic [4:0] outs(input state_t s);
    case (s)
      RECV:    outs = 5'b11001;
      WRITE:   outs = 5'b01001;
      CHECK:   outs = 5'b11001;
      DONE:    outs = 5'b00100;
      ERROR:   outs = 5'b00011;
      default: outs = 5'b00001;
    endcase
  endfunction

  assign index_inc = index + ONE;

  // Loader FSM: byte assembly, memory write strobe, checksum check, core reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      count      <= '0;
      index      <= '0;
      byte_cnt   <= '0;
      csum       <= '0;
      word       <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      {byte_ready, busy, done, error, cpu_rst} <= outs(IDLE);
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            if (word_count > CAPACITY) begin
              state <= ERROR;
              {byte_ready, busy, done, error, cpu_rst} <= outs(ERROR);
            end else begin
              count    <= word_count;
              index    <= '0;
              byte_cnt <= '0;
              csum     <= '0;
              if (word_count != '0) begin
                state <= RECV;
                {byte_ready, busy, done, error, cpu_rst} <= outs(RECV);
              end else begin
                state <= CHECK;
                {byte_ready, busy, done, error, cpu_rst} <= outs(CHECK);
              end
            end
          end
        end

        RECV: begin
          if (byte_valid) begin
            csum     <= csum ^ byte_in;
            word     <= {word[15:0], byte_in};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              // Word complete: present it to memory in the next cycle.
              state     <= WRITE;
              mem_we    <= 1'b1;
              mem_addr  <= {{(29 - ADDR_W){1'b0}}, index, 2'b00};
              mem_wdata <= {word, byte_in};
              {byte_ready, busy, done, error, cpu_rst} <= outs(WRITE);
            end
          end
        end

        WRITE: begin
          index <= index_inc;
          if (index_inc == count) begin
            state <= CHECK;
            {byte_ready, busy, done, error, cpu_rst} <= outs(CHECK);
          end else begin
            state <= RECV;
            {byte_ready, busy, done, error, cpu_rst} <= outs(RECV);
          end
        end

        CHECK: begin
          if (byte_valid) begin
            // The checksum byte itself is compared, never accumulated.
            if (byte_in == csum) begin
              state <= DONE;
              {byte_ready, busy, done, error, cpu_rst} <= outs(DONE);
            end else begin
              state <= ERROR;
              {byte_ready, busy, done, error, cpu_rst} <= outs(ERROR);
            end
          end
        end

        default: begin
          state <= IDLE;
          {byte_ready, busy, done, error, cpu_rst} <= outs(IDLE);
        end
      endcase
    end
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader sitting directly upstream of the multicycle MIPS `Integration` core. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. It writes them into the core's unified instruction/data memory from address 0 and checks a trailing XOR checksum. It holds the core in reset until a load completes cleanly, replacing the fixed 100 ns reset pulse used in bring-up benches.

## Interface
- `ADDR_W`, 8, word-address width; capacity is 2**ADDR_W words.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  pulse; begins a load; sampled only in IDLE, DONE, ERROR.
- `word_count`  in  ADDR_W+1  number of words to load; sampled on accepted `start`.
- `byte_in`  in  8  stream data.
- `byte_valid`  in  1  `byte_in` valid.
- `byte_ready`  out  1  loader can accept a byte.
- `mem_addr`  out  32  byte address of write, equal to word_index*4.
- `mem_wdata`  out  32  assembled word.
- `mem_we`  out  1  one-cycle write strobe.
- `cpu_rst`  out  1  active-high reset to the core; high unless in DONE.
- `busy`  out  1  high in RECV, WRITE, CHECK.
- `done`  out  1  high in DONE.
- `error`  out  1  high in ERROR.

## Operation
- States are IDLE, RECV, WRITE, CHECK, DONE, ERROR.
- **IDLE**
  - If `start`=1 and `word_count` > 2**ADDR_W, go to ERROR.
  - Otherwise, on `start`, latch the count, clear the word index, byte counter (2-bit) and checksum accumulator.
  - Then go to RECV if count > 0, else to CHECK.
- **RECV**
  - `byte_ready`=1. A byte transfers when `byte_valid` & `byte_ready`.
  - Byte k of a word (k=0..3) goes to bits [31-8k:24-8k]. Byte 0 is the MSB (big-endian).
  - Every accepted byte is XORed into the checksum.
  - On acceptance of byte 3, go to WRITE.
- **WRITE**
  - `byte_ready`=0; `mem_we`=1 for exactly this cycle; `mem_addr`={index,2'b00} zero-extended; `mem_wdata` = assembled word.
  - Increment the index.
  - If the index equals the count after the increment, go to CHECK; else go to RECV.
- **CHECK**
  - `byte_ready`=1. The accepted byte is compared with the accumulator; it is not XORed in.
  - Equal: go to DONE. Unequal: go to ERROR.
- **DONE**: `cpu_rst`=0 and `done`=1. `start` re-enters the load sequence exactly as from IDLE, and `cpu_rst` returns to 1 on that edge.
- **ERROR**: `cpu_rst`=1 and `error`=1. `start` restarts the load exactly as from IDLE.
- `start` while `busy` is ignored.
- `byte_valid` while not ready is not consumed; the source must hold the byte.
- `byte_ready` is a function of state only; it does not depend on `byte_valid`.
- `mem_addr` and `mem_wdata` are don't-care when `mem_we`=0, but must be stable registers (no glitching).

## Timing
- **Reset** (`rst`=0, asynchronous):
  - State is IDLE.
  - `cpu_rst`=1; `byte_ready`, `mem_we`, `busy`, `done`, `error` = 0.
  - `mem_addr`, `mem_wdata`, index, byte counter and checksum = 0.
- Reset mid-load abandons it; no further `mem_we` is issued. A partial word is never written.
- Reset release: the first edge with `rst`=1 may accept `start`.
- **Throughput**:
  - With `byte_valid` held high, one word takes 5 cycles (4 RECV + 1 WRITE).
  - N words plus the checksum byte take 5N+1 cycles from the first byte-accept cycle to entering DONE/ERROR.
- **Output registration**:
  - `mem_we` is registered; it is asserted in the cycle after byte 3 is accepted.
  - `cpu_rst` deasserts in the first cycle of DONE, one cycle after the checksum byte is accepted.
  - `done`, `error` and `cpu_rst` are registered outputs.
- **Boundaries**:
  - `word_count`=0 goes straight to CHECK; the expected checksum is 0x00.
  - `word_count`=2**ADDR_W is legal. The last word lands at byte address (2**ADDR_W-1)*4, and the index does not wrap before CHECK.

## Test plan
- Good load:
  - Stimulus: ADDR_W=8, `word_count`=2, bytes 20 08 00 05 AC 08 00 00, checksum 89, `byte_valid` continuous.
  - Response: writes (0x0, 0x20080005) and (0x4, 0xAC080000), each with a single-cycle `mem_we`; DONE 11 cycles after the first accept; `cpu_rst`=0; `done`=1.
- Bad checksum:
  - Stimulus: the same stream with checksum 88.
  - Response: both writes occur; ERROR; `error`=1; `cpu_rst` stays 1. Then `start` with the good stream reaches DONE.
- Backpressure and gaps:
  - Stimulus: the good stream with `byte_valid` dropped for 3 cycles between random bytes.
  - Response: identical writes and checksum result.
  - Also check: no byte is consumed during WRITE, and `byte_ready`=0 there.
- Boundary counts:
  - `word_count`=0 with checksum 00 → DONE one cycle after the checksum accept.
  - `word_count`=257 → ERROR with no `mem_we`.
  - `word_count`=256 → last write at 0x3FC.
- Async reset mid-load: assert `rst`=0 after 2 bytes of word 1 (the second word).
  - Outputs return to reset values immediately, without waiting for a clock edge.
  - No further `mem_we`; `cpu_rst`=1.
  - A subsequent good load succeeds from address 0.
- Ignored start: pulse `start` with `word_count`=5 during RECV → no effect; the load completes with the original count.
